// File: rtl/pc_predict_unit_if.sv
// Fetch/resolve bundle between the next-PC unit and the pipeline front end.
// master = pc_predict_unit, slave = IF/EX side.
interface pc_predict_unit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic                  fetch_ready_i;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  pc_valid_o;
    logic                  pred_taken_o;
    logic [DATA_WIDTH-1:0] pred_target_o;
    logic                  res_valid_i;
    logic [2:0]            res_specinst_i;
    logic [2:0]            res_detail_i;
    logic [DATA_WIDTH-1:0] res_pc_i;
    logic [DATA_WIDTH-1:0] res_rs1_i;
    logic [DATA_WIDTH-1:0] res_imme_i;
    logic [DATA_WIDTH-1:0] res_aluout_i;
    logic [DATA_WIDTH-1:0] res_pred_target_i;
    logic                  redirect_o;
    logic [DATA_WIDTH-1:0] redirect_pc_o;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_o;

    modport master (
        input  fetch_ready_i,
        input  res_valid_i, res_specinst_i, res_detail_i,
        input  res_pc_i, res_rs1_i, res_imme_i, res_aluout_i,
        input  res_pred_target_i,
        output pc_o, pc_valid_o, pred_taken_o, pred_target_o,
        output redirect_o, redirect_pc_o, mispredict_cnt_o
    );

    modport slave (
        output fetch_ready_i,
        output res_valid_i, res_specinst_i, res_detail_i,
        output res_pc_i, res_rs1_i, res_imme_i, res_aluout_i,
        output res_pred_target_i,
        input  pc_o, pc_valid_o, pred_taken_o, pred_target_o,
        input  redirect_o, redirect_pc_o, mispredict_cnt_o
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register, direct-mapped BTB predictor and EX-stage redirect.
// Define PCU_BTB_EN to build the BTB; otherwise prediction is always pc+4.
module pc_predict_unit #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VEC   = 64'h0000_0000_8000_0000,
    parameter int                    BTB_ENTRIES = 8,
    parameter int                    CNT_WIDTH   = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    pc_predict_unit_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] pc_q;
    logic                  valid_q;
    logic                  redir_q;
    logic [DATA_WIDTH-1:0] redir_pc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    logic                  is_br;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  br_taken;
    logic [DATA_WIDTH-1:0] seq_pc;
    logic [DATA_WIDTH-1:0] rel_pc;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] actual_pc;
    logic                  mispredict;

    assign is_br   = (bus.res_specinst_i == 3'd0);
    assign is_jal  = (bus.res_specinst_i == 3'd1);
    assign is_jalr = (bus.res_specinst_i == 3'd2);

    assign seq_pc   = bus.res_pc_i + FOUR;
    assign rel_pc   = bus.res_pc_i + bus.res_imme_i;
    assign jalr_sum = bus.res_rs1_i + bus.res_imme_i;

    // aluout carries the comparison result: zero/nonzero or an SLT bit
    always_comb begin
        br_taken = 1'b0;
        case (bus.res_detail_i)
            3'b000, 3'b101, 3'b111: br_taken = (bus.res_aluout_i == '0);
            3'b001:                 br_taken = (bus.res_aluout_i != '0);
            3'b100, 3'b110:         br_taken = (bus.res_aluout_i == ONE);
            default:                br_taken = 1'b0;
        endcase
    end

    always_comb begin
        actual_pc = seq_pc;
        unique case (1'b1)
            is_br:   actual_pc = br_taken ? rel_pc : seq_pc;
            is_jal:  actual_pc = rel_pc;
            is_jalr: actual_pc = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            default: actual_pc = seq_pc;
        endcase
    end

    assign mispredict = bus.res_valid_i &&
                        (actual_pc != bus.res_pred_target_i);

`ifdef PCU_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [1:0]             btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             alloc;

    assign f_idx = pc_q[IDX_W+1:2];
    assign f_tag = pc_q[DATA_WIDTH-1:IDX_W+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign pred_taken  = f_hit && (btb_jump[f_idx] || btb_ctr[f_idx][1]);
    assign pred_target = pred_taken ? btb_target[f_idx] : pc_q + FOUR;

    assign r_idx = bus.res_pc_i[IDX_W+1:2];
    assign r_tag = bus.res_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
    assign alloc = bus.res_valid_i && ((is_br && br_taken) || is_jal);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_valid <= '0;
        end else if (alloc) begin
            btb_valid[r_idx] <= 1'b1;
        end
    end

    // payload is only meaningful behind a valid bit, so it is not reset
    always_ff @(posedge clk_i) begin
        if (bus.res_valid_i) begin
            unique case (1'b1)
                is_br && br_taken: begin
                    btb_target[r_idx] <= actual_pc;
                    if (r_hit) begin
                        if (btb_ctr[r_idx] != 2'b11)
                            btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'b01;
                    end else begin
                        btb_tag[r_idx]  <= r_tag;
                        btb_ctr[r_idx]  <= 2'b10;
                        btb_jump[r_idx] <= 1'b0;
                    end
                end
                is_br && !br_taken: begin
                    if (r_hit && btb_ctr[r_idx] != 2'b00)
                        btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'b01;
                end
                is_jal: begin
                    btb_tag[r_idx]    <= r_tag;
                    btb_jump[r_idx]   <= 1'b1;
                    btb_target[r_idx] <= actual_pc;
                end
                default: ;
            endcase
        end
    end
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_q + FOUR;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q <= 1'b1;
            redir_q <= mispredict;
            if (mispredict) begin
                pc_q       <= actual_pc;
                redir_pc_q <= actual_pc;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end else if (valid_q && bus.fetch_ready_i) begin
                pc_q <= pred_target;
            end
        end
    end

    assign bus.pc_o             = pc_q;
    assign bus.pc_valid_o       = valid_q;
    assign bus.pred_taken_o     = pred_taken;
    assign bus.pred_target_o    = pred_target;
    assign bus.redirect_o       = redir_q;
    assign bus.redirect_pc_o    = redir_pc_q;
    assign bus.mispredict_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Randomised bench for pc_predict_unit against a per-address BTB model.
// Honours PCU_BTB_EN the same way the design does.
module tb_pc_predict_unit;
    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_predict_unit_if #(.DATA_WIDTH(64), .CNT_WIDTH(4)) vi ();

    pc_predict_unit #(.CNT_WIDTH(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (vi.master)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] m_pc;
    bit          m_valid;
    bit          m_redir;
    logic [63:0] m_redir_pc;
    int          m_cnt;

    // BTB model: each slot is owned by at most one word address
    logic [61:0] owner [8];
    bit          owned [8];
    int          ctr_of [logic [61:0]];
    bit          jmp_of [logic [61:0]];
    logic [63:0] tgt_of [logic [61:0]];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_br_taken(logic [2:0] d, logic [63:0] a);
        case (d)
            3'd0, 3'd5, 3'd7: return a == 64'd0;
            3'd1:             return a != 64'd0;
            3'd4, 3'd6:       return a == 64'd1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_actual(logic [2:0] sp, logic [2:0] d,
        logic [63:0] pc, logic [63:0] rs1, logic [63:0] imm, logic [63:0] alu);
        if (sp == 3'd0) return m_br_taken(d, alu) ? pc + imm : pc + 64'd4;
        if (sp == 3'd1) return pc + imm;
        if (sp == 3'd2) return (rs1 + imm) & ~64'd1;
        return pc + 64'd4;
    endfunction

`ifdef PCU_BTB_EN
    function automatic bit m_hit(logic [63:0] pc);
        logic [61:0] k = pc[63:2];
        int i = int'(k % 62'd8);
        return owned[i] && owner[i] == k;
    endfunction

    task automatic btb_update(logic [63:0] pc, logic [2:0] sp, logic [2:0] d,
        logic [63:0] alu, logic [63:0] act);
        logic [61:0] k = pc[63:2];
        int i = int'(k % 62'd8);
        bit h = m_hit(pc);
        bit tk = m_br_taken(d, alu);
        if (sp == 3'd0 && tk) begin
            if (h) begin
                if (ctr_of[k] < 3) ctr_of[k]++;
            end else begin
                owner[i] = k; owned[i] = 1; ctr_of[k] = 2; jmp_of[k] = 0;
            end
            tgt_of[k] = act;
        end else if (sp == 3'd0) begin
            if (h && ctr_of[k] > 0) ctr_of[k]--;
        end else if (sp == 3'd1) begin
            owner[i] = k; owned[i] = 1; jmp_of[k] = 1; tgt_of[k] = act;
            if (!ctr_of.exists(k)) ctr_of[k] = 0;
        end
    endtask
`endif

    function automatic bit m_pred_taken(logic [63:0] pc);
`ifdef PCU_BTB_EN
        logic [61:0] k = pc[63:2];
        if (m_hit(pc)) return jmp_of[k] || ctr_of[k] >= 2;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_pred_target(logic [63:0] pc);
`ifdef PCU_BTB_EN
        if (m_pred_taken(pc)) return tgt_of[pc[63:2]];
`endif
        return pc + 64'd4;
    endfunction

    task automatic m_reset();
        m_pc = RV; m_valid = 0; m_redir = 0; m_redir_pc = '0; m_cnt = 0;
        for (int i = 0; i < 8; i++) owned[i] = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("pc_o", vi.pc_o, m_pc);
            chk("pc_valid_o", 64'(vi.pc_valid_o), 64'(m_valid));
            chk("pred_taken_o", 64'(vi.pred_taken_o), 64'(m_pred_taken(m_pc)));
            chk("pred_target_o", vi.pred_target_o, m_pred_target(m_pc));
            chk("redirect_o", 64'(vi.redirect_o), 64'(m_redir));
            if (m_redir) chk("redirect_pc_o", vi.redirect_pc_o, m_redir_pc);
            chk("mispredict_cnt_o", 64'(vi.mispredict_cnt_o), 64'(m_cnt));
        end
    end

    // one clock: model next state is taken from pre-edge inputs/state
    task automatic cycle();
        logic [63:0] act, npc;
        bit misp;
        act = m_actual(vi.res_specinst_i, vi.res_detail_i, vi.res_pc_i,
                       vi.res_rs1_i, vi.res_imme_i, vi.res_aluout_i);
        misp = vi.res_valid_i && act != vi.res_pred_target_i;
        npc = misp ? act : (m_valid && vi.fetch_ready_i) ? m_pred_target(m_pc) : m_pc;
        @(posedge clk);
        m_pc = npc; m_valid = 1; m_redir = misp;
        if (misp) begin
            m_redir_pc = act;
            if (m_cnt < CMAX) m_cnt++;
        end
`ifdef PCU_BTB_EN
        if (vi.res_valid_i)
            btb_update(vi.res_pc_i, vi.res_specinst_i, vi.res_detail_i, vi.res_aluout_i, act);
`endif
        @(negedge clk);
    endtask

    task automatic set_res(bit v, logic [2:0] sp, logic [2:0] d, logic [63:0] pc,
        logic [63:0] rs1, logic [63:0] imm, logic [63:0] alu, logic [63:0] pt);
        vi.res_valid_i = v; vi.res_specinst_i = sp; vi.res_detail_i = d;
        vi.res_pc_i = pc; vi.res_rs1_i = rs1; vi.res_imme_i = imm;
        vi.res_aluout_i = alu; vi.res_pred_target_i = pt;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        vi.res_valid_i = 1'b0;
        #1;
        chk("rst pc_o", vi.pc_o, RV);
        chk("rst redirect_o", 64'(vi.redirect_o), 64'd0);
        chk("rst pc_valid_o", 64'(vi.pc_valid_o), 64'd0);
        chk("rst mispredict_cnt_o", 64'(vi.mispredict_cnt_o), 64'd0);
        m_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_drive();
        logic [63:0] pc, tgt, imm, rs1, alu, act, pt;
        logic [2:0] sp, d;
        int i, r;
        i = $urandom_range(0, 7);
        pc = RV + ($urandom_range(0, 1) ? 64'h100 : 64'h0) + 64'(4 * i);
        tgt = RV + ($urandom_range(0, 1) ? 64'h100 : 64'h0) + 64'(4 * $urandom_range(0, 7));
        sp = (i < 5) ? 3'd0 : (i == 5) ? 3'd1 : (i == 6) ? 3'd2 : 3'($urandom_range(3, 7));
        d = 3'($urandom_range(0, 7));
        r = $urandom_range(0, 2);
        alu = (r == 0) ? 64'd0 : (r == 1) ? 64'd1 : {$urandom, $urandom};
        imm = tgt - pc;
        if (sp == 3'd2) begin
            imm = 64'(2 * $urandom_range(0, 15));
            rs1 = tgt - imm + 64'($urandom_range(0, 1));
        end else begin
            rs1 = {$urandom, $urandom};
        end
        act = m_actual(sp, d, pc, rs1, imm, alu);
        r = $urandom_range(0, 9);
        pt = (r < 4) ? m_pred_target(pc) : (r < 7) ? act : pc + 64'd4;
        set_res($urandom_range(0, 3) != 0, sp, d, pc, rs1, imm, alu, pt);
        vi.fetch_ready_i = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit btb;
`ifdef PCU_BTB_EN
        btb = 1;
`else
        btb = 0;
`endif
        rst = 1'b1;
        vi.fetch_ready_i = 1'b1;
        set_res(0, 3'd3, 3'd0, '0, '0, '0, '0, '0);
        m_reset();
        @(negedge clk);
        do_reset();
        chk("T1 valid0", 64'(vi.pc_valid_o), 64'd0);
        cycle();
        chk("T1 valid1", 64'(vi.pc_valid_o), 64'd1);
        chk("T1 pc0", vi.pc_o, 64'h8000_0000);
        cycle();
        chk("T1 pc1", vi.pc_o, 64'h8000_0004);
        cycle();
        chk("T1 pc2", vi.pc_o, 64'h8000_0008);

        set_res(1, 3'd0, 3'b000, 64'h8000_0010, '0, 64'h40, 64'd0, 64'h8000_0014);
        cycle();
        chk("T2 redirect", 64'(vi.redirect_o), 64'd1);
        chk("T2 pc", vi.pc_o, 64'h8000_0050);
        chk("T2 redirect_pc", vi.redirect_pc_o, 64'h8000_0050);
        chk("T2 cnt", 64'(vi.mispredict_cnt_o), 64'd1);

        set_res(1, 3'd2, 3'd0, 64'h8000_0000, 64'h8000_0010, '0, '0, '0);
        cycle();
        set_res(0, 3'd3, 3'd0, '0, '0, '0, '0, '0);
        chk("T3 pred_taken", 64'(vi.pred_taken_o), btb ? 64'd1 : 64'd0);
        chk("T3 pred_target", vi.pred_target_o, btb ? 64'h8000_0050 : 64'h8000_0014);
        set_res(1, 3'd0, 3'b000, 64'h8000_0010, '0, 64'h40, 64'd0,
                btb ? 64'h8000_0050 : 64'h8000_0014);
        cycle();
        chk("T3 redirect", 64'(vi.redirect_o), btb ? 64'd0 : 64'd1);

        set_res(1, 3'd0, 3'b000, 64'h8000_0010, '0, 64'h40, 64'd1, 64'h8000_0014);
        cycle();
        cycle();
        set_res(1, 3'd2, 3'd0, 64'h8000_0000, 64'h8000_0010, '0, '0, '0);
        cycle();
        set_res(0, 3'd3, 3'd0, '0, '0, '0, '0, '0);
        chk("T4 pred_taken", 64'(vi.pred_taken_o), 64'd0);
        chk("T4 pred_target", vi.pred_target_o, 64'h8000_0014);

        vi.fetch_ready_i = 1'b1;
        set_res(1, 3'd2, 3'd0, 64'h8000_0020, 64'h8000_1001, 64'd2, '0, 64'h8000_0024);
        cycle();
        chk("T5 redirect", 64'(vi.redirect_o), 64'd1);
        chk("T5 pc", vi.pc_o, 64'h8000_1002);
        chk("T5 redirect_pc", vi.redirect_pc_o, 64'h8000_1002);

        do_reset();
        set_res(1, 3'd2, 3'd0, 64'h8000_0000, 64'h8000_0010, '0, '0, '0);
        cycle();
        set_res(0, 3'd3, 3'd0, '0, '0, '0, '0, '0);
        chk("T6 pred_taken", 64'(vi.pred_taken_o), 64'd0);
        chk("T6 pred_target", vi.pred_target_o, 64'h8000_0014);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            rand_drive();
            cycle();
        end

        vi.fetch_ready_i = 1'b1;
        set_res(1, 3'd2, 3'd0, 64'h8000_0000, 64'h8000_0040, '0, '0, '0);
        for (int n = 0; n < 20; n++) cycle();
        chk("cnt saturate", 64'(vi.mispredict_cnt_o), 64'd15);
        set_res(0, 3'd3, 3'd0, '0, '0, '0, '0, '0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
